// File: rtl/word_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : word_serializer_pkg
//  Purpose : Shared types, default geometry and the beat select helper for
//            word_serializer.
//  Contents: ser_state_e  - 2-bit FSM state encoding (IDLE, WAIT, SHIFT)
//            SIZE_DEF     - default word width
//            OUT_W_DEF    - default beat width
//            SER_MAX_W    - widest word the helper can handle
//            beat_sel()   - returns beat number idx of a word, LSB- or
//                           MSB-first ordering
//  Revision: 1.0 - initial release
// ============================================================================
package word_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2
  } ser_state_e;

  localparam int unsigned SIZE_DEF  = 32;
  localparam int unsigned OUT_W_DEF = 8;
  localparam int unsigned SER_MAX_W = 256;

  // The word is passed zero-extended to SER_MAX_W so that one helper serves
  // every geometry. The requested beat lands in the low out_w bits of the
  // result; the caller truncates to its beat width.
  function automatic logic [SER_MAX_W-1:0] beat_sel(
    input logic [SER_MAX_W-1:0] word,
    input int unsigned          idx,
    input bit                   msb_first,
    input int unsigned          out_w,
    input int unsigned          ratio
  );
    int unsigned pos;
    pos = msb_first ? (ratio - 1 - idx) : idx;
    return word >> (pos * out_w);
  endfunction

endpackage : word_serializer_pkg
`default_nettype wire

// File: rtl/word_serializer.sv
`default_nettype none
// ============================================================================
//  Module  : word_serializer
//  Purpose : Pops SIZE-bit words from a FIFO read port (pop pulse, data one
//            cycle later) and emits each as RATIO = SIZE/OUT_W beats on a
//            valid/ready stream, flagging the final beat of every word.
//  Ports   : clk_i        - clock, rising edge
//            rst_i        - asynchronous reset, active low
//            avail_i      - FIFO holds at least one unread word
//            pop_o        - one-cycle FIFO read request
//            word_valid_i - FIFO read data valid
//            word_i       - FIFO read data
//            beat_o       - current beat
//            beat_valid_o - beat_o valid
//            beat_ready_i - sink accepts the beat
//            beat_last_o  - final beat of the word
//            err_o        - sticky: word_valid_i seen while not waiting
//  Revision: 1.0 - initial release
// ============================================================================
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int unsigned SIZE      = SIZE_DEF,
  parameter int unsigned OUT_W     = OUT_W_DEF,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             avail_i,
  output logic             pop_o,
  input  logic             word_valid_i,
  input  logic [SIZE-1:0]  word_i,
  output logic [OUT_W-1:0] beat_o,
  output logic             beat_valid_o,
  input  logic             beat_ready_i,
  output logic             beat_last_o,
  output logic             err_o
);

  localparam int unsigned RATIO = SIZE / OUT_W;
  localparam int unsigned CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(RATIO - 1);

  generate
    if ((SIZE % OUT_W) != 0 || RATIO < 2 || SIZE > SER_MAX_W) begin : g_param_check
      $error("word_serializer: SIZE must be a multiple of OUT_W with SIZE/OUT_W >= 2 and SIZE <= SER_MAX_W");
    end
  endgenerate

  // Registered state and outputs
  ser_state_e       r_state;
  logic             r_pop;
  logic             r_beat_valid;
  logic             r_beat_last;
  logic [OUT_W-1:0] r_beat;
  logic             r_err;
  logic [CW-1:0]    r_cnt;
  logic [SIZE-1:0]  r_shift;

  // Next-state values
  ser_state_e       w_state_n;
  logic             w_pop_n;
  logic             w_beat_valid_n;
  logic             w_beat_last_n;
  logic [OUT_W-1:0] w_beat_n;
  logic             w_err_n;
  logic [CW-1:0]    w_cnt_n;
  logic [SIZE-1:0]  w_shift_n;

  logic             w_accept;
  logic [CW-1:0]    w_cnt_inc;

  assign w_accept  = r_beat_valid && beat_ready_i;
  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= IDLE;
      r_pop        <= 1'b0;
      r_beat_valid <= 1'b0;
      r_beat_last  <= 1'b0;
      r_beat       <= '0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      r_shift      <= '0;
    end else begin
      r_state      <= w_state_n;
      r_pop        <= w_pop_n;
      r_beat_valid <= w_beat_valid_n;
      r_beat_last  <= w_beat_last_n;
      r_beat       <= w_beat_n;
      r_err        <= w_err_n;
      r_cnt        <= w_cnt_n;
      r_shift      <= w_shift_n;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_pop_n        = 1'b0;
    w_beat_valid_n = r_beat_valid;
    w_beat_last_n  = r_beat_last;
    w_beat_n       = r_beat;
    w_cnt_n        = r_cnt;
    w_shift_n      = r_shift;
    // A FIFO response is only expected while a pop is outstanding.
    w_err_n        = r_err | (word_valid_i && (r_state != WAIT));

    unique case (r_state)
      IDLE: begin
        if (avail_i) begin
          w_pop_n   = 1'b1;
          w_state_n = WAIT;
        end
      end

      WAIT: begin
        if (word_valid_i) begin
          w_shift_n      = word_i;
          w_cnt_n        = '0;
          w_beat_valid_n = 1'b1;
          w_beat_last_n  = 1'b0;
          w_beat_n       = OUT_W'(beat_sel(SER_MAX_W'(word_i), 0, MSB_FIRST, OUT_W, RATIO));
          w_state_n      = SHIFT;
        end
      end

      SHIFT: begin
        // Beat registers hold while valid && !ready.
        if (w_accept) begin
          if (r_cnt == C_LAST) begin
            w_beat_valid_n = 1'b0;
            w_beat_last_n  = 1'b0;
            w_cnt_n        = '0;
            // Chain straight into the next pop so a busy FIFO costs only
            // the two-cycle read turnaround between words.
            if (avail_i) begin
              w_pop_n   = 1'b1;
              w_state_n = WAIT;
            end else begin
              w_state_n = IDLE;
            end
          end else begin
            w_cnt_n       = w_cnt_inc;
            w_beat_last_n = (w_cnt_inc == C_LAST);
            w_beat_n      = OUT_W'(beat_sel(SER_MAX_W'(r_shift), 32'(w_cnt_inc), MSB_FIRST, OUT_W, RATIO));
          end
        end
      end

      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  assign pop_o        = r_pop;
  assign beat_o       = r_beat;
  assign beat_valid_o = r_beat_valid;
  assign beat_last_o  = r_beat_last;
  assign err_o        = r_err;

endmodule : word_serializer
`default_nettype wire

// File: tb/tb_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_word_serializer
//  Purpose : Directed self-checking bench for word_serializer (SIZE=32,
//            OUT_W=8). Two instances share all inputs: LSB-first and
//            MSB-first. A small FIFO model answers each pop one cycle later.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_word_serializer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        avail_i = 1'b0;
  logic        word_valid_i = 1'b0;
  logic [31:0] word_i = '0;
  logic        beat_ready_i = 1'b0;

  logic        pop_o, beat_valid_o, beat_last_o, err_o;
  logic [7:0]  beat_o;
  logic        pop_m, beat_valid_m, beat_last_m, err_m;
  logic [7:0]  beat_m;

  word_serializer #(.SIZE(32), .OUT_W(8), .MSB_FIRST(1'b0)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .avail_i(avail_i), .pop_o(pop_o),
    .word_valid_i(word_valid_i), .word_i(word_i), .beat_o(beat_o),
    .beat_valid_o(beat_valid_o), .beat_ready_i(beat_ready_i),
    .beat_last_o(beat_last_o), .err_o(err_o)
  );

  word_serializer #(.SIZE(32), .OUT_W(8), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk_i(clk), .rst_i(rst_i), .avail_i(avail_i), .pop_o(pop_m),
    .word_valid_i(word_valid_i), .word_i(word_i), .beat_o(beat_m),
    .beat_valid_o(beat_valid_m), .beat_ready_i(beat_ready_i),
    .beat_last_o(beat_last_m), .err_o(err_m)
  );

  always #5 clk = ~clk;

  // ---------------- monitor (mid-cycle, away from the active edge) --------
  logic [7:0] beat_q[$];
  logic       last_q[$];
  logic [7:0] msb_q[$];
  int         bcyc_q[$];
  int         pop_cyc_q[$];
  int         pop_m_cnt = 0;
  int         cyc = 0;

  always @(negedge clk) begin
    if (pop_o) pop_cyc_q.push_back(cyc);
    if (pop_m) pop_m_cnt++;
    if (beat_valid_o && beat_ready_i) begin
      beat_q.push_back(beat_o);
      last_q.push_back(beat_last_o);
      msb_q.push_back(beat_m);
      bcyc_q.push_back(cyc);
    end
    cyc++;
  end

  // ---------------- checking ----------------------------------------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- FIFO model --------------------------------------------
  logic [31:0] fifo_q[$];
  logic [31:0] cur_word = '0;
  logic        pend = 1'b0;
  logic        inject = 1'b0;

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    avail_i = 1'b1;
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    word_valid_i = pend | inject;
    if (pend)        word_i = cur_word;
    else if (inject) word_i = 32'hBAD0_BAD0;
    inject = 1'b0;
    pend   = 1'b0;
    if (pop_o && fifo_q.size() > 0) begin
      cur_word = fifo_q.pop_front();
      pend     = 1'b1;
    end
    avail_i = (fifo_q.size() > 0);
  endtask

  task automatic wait_beats(input int base, input int n, input int budget);
    int k;
    k = 0;
    while ((beat_q.size() - base) < n && k < budget) begin
      step();
      k++;
    end
    if ((beat_q.size() - base) < n)
      chk("timeout_beats", beat_q.size() - base, n);
  endtask

  // Checks 4 beats of word w starting at index base, both orderings.
  task automatic chk_word(input string tag, input int base, input logic [31:0] w);
    logic [31:0] ww;
    ww = w;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_lsb_beat"}, beat_q[base+i], ww[8*i +: 8]);
      chk({tag, "_msb_beat"}, msb_q[base+i], ww[8*(3-i) +: 8]);
      chk({tag, "_last"}, last_q[base+i], (i == 3));
    end
  endtask

  function automatic logic [31:0] outs_now();
    return {20'd0, pop_o, beat_valid_o, beat_last_o, err_o, beat_o};
  endfunction

  // ---------------- stimulus ----------------------------------------------
  int b0, p0;

  initial begin
    // Reset state
    repeat (3) step();
    chk("reset_outputs", outs_now(), 32'd0);
    chk("reset_outputs_msb", {pop_m, beat_valid_m, beat_last_m, err_m, beat_m}, 32'd0);
    rst_i = 1'b1;
    repeat (2) step();

    // 1: single word, ready held high
    beat_ready_i = 1'b1;
    b0 = beat_q.size(); p0 = pop_cyc_q.size();
    push_word(32'hDDCC_BBAA);
    wait_beats(b0, 4, 40);
    repeat (6) step();
    chk("t1_beat_count", beat_q.size() - b0, 4);
    chk_word("t1", b0, 32'hDDCC_BBAA);
    chk("t1_consecutive", bcyc_q[b0+3] - bcyc_q[b0], 3);
    chk("t1_pop_count", pop_cyc_q.size() - p0, 1);
    chk("t1_pop_to_beat0", bcyc_q[b0] - pop_cyc_q[p0], 2);

    // 2: back-to-back words
    b0 = beat_q.size(); p0 = pop_cyc_q.size();
    push_word(32'h0302_0100);
    push_word(32'h0706_0504);
    wait_beats(b0, 8, 60);
    repeat (6) step();
    chk("t2_beat_count", beat_q.size() - b0, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t2_beat", beat_q[b0+i], i);
      chk("t2_last", last_q[b0+i], (i % 4) == 3);
    end
    chk("t2_gap", bcyc_q[b0+4] - bcyc_q[b0+3], 3);
    chk("t2_pop_count", pop_cyc_q.size() - p0, 2);
    chk("t2_pop2_after_last", pop_cyc_q[p0+1] - bcyc_q[b0+3], 1);

    // 3: backpressure on beat 1
    b0 = beat_q.size(); p0 = pop_cyc_q.size();
    push_word(32'hDDCC_BBAA);
    for (int k = 0; k < 20; k++) begin
      step();
      if (beat_valid_o && beat_o == 8'hBB) break;
    end
    beat_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold", {beat_valid_o, beat_o}, {1'b1, 8'hBB});
      step();
    end
    beat_ready_i = 1'b1;
    wait_beats(b0, 4, 40);
    repeat (6) step();
    chk("t3_beat_count", beat_q.size() - b0, 4);
    chk_word("t3", b0, 32'hDDCC_BBAA);
    chk("t3_pop_count", pop_cyc_q.size() - p0, 1);

    // 4: FIFO empty for 20 cycles
    b0 = beat_q.size(); p0 = pop_cyc_q.size();
    for (int k = 0; k < 20; k++) begin
      step();
      chk("t4_idle", {pop_o, beat_valid_o}, 2'b00);
    end
    chk("t4_no_pop", pop_cyc_q.size() - p0, 0);

    // 5: unsolicited word_valid_i in IDLE
    chk("t5_err_before", err_o, 1'b0);
    inject = 1'b1;
    step();
    step();
    chk("t5_err_set", err_o, 1'b1);
    chk("t5_err_set_msb", err_m, 1'b1);
    repeat (6) step();
    chk("t5_err_sticky", err_o, 1'b1);
    chk("t5_no_beats", beat_q.size() - b0, 0);

    // 6: reset after the second beat
    b0 = beat_q.size();
    push_word(32'hDDCC_BBAA);
    wait_beats(b0, 2, 40);
    rst_i = 1'b0;
    #1;
    chk("t6_async_clear", outs_now(), 32'd0);
    step();
    chk("t6_in_reset", outs_now(), 32'd0);
    rst_i = 1'b1;
    pend = 1'b0;
    word_valid_i = 1'b0;
    fifo_q.delete();
    avail_i = 1'b0;
    step();
    b0 = beat_q.size();
    push_word(32'h4433_2211);
    wait_beats(b0, 4, 40);
    repeat (6) step();
    chk("t6_beat_count", beat_q.size() - b0, 4);
    chk_word("t6", b0, 32'h4433_2211);
    chk("t6_err_cleared", err_o, 1'b0);

    chk("msb_pop_match", pop_m_cnt, pop_cyc_q.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_word_serializer
`default_nettype wire
